// File: rtl/pwm_pkg.sv
// Shared types and default parameters for the multi-channel servo PWM block.
// No logic, so no latency; no flow control of its own.
// Backpressure: none.
package pwm_pkg;

  localparam int CNT_W_DEF    = 16;
  localparam int DUTY_RST_DEF = 1500;
  localparam int MIN_US_DEF   = 500;
  localparam int MAX_US_DEF   = 2500;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } pwm_state_t;

endpackage

// File: rtl/pwm_tick_gen.sv
// Microsecond prescaler: one-clk tick every CLK_DIV clks while run is high.
// Latency: first tick CLK_DIV clks after run rises; combinational from the count.
// Backpressure: none; the count is held at 0 whenever run is low.
module pwm_tick_gen #(
  parameter int CLK_DIV = 100
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic tick
);

  localparam int               PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(CLK_DIV - 1);
  localparam logic [PRE_W-1:0] PRE_ONE = PRE_W'(1);

  logic [PRE_W-1:0] pre;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre <= '0;
    end else if (!run || pre == PRE_MAX) begin
      pre <= '0;
    end else begin
      pre <= pre + PRE_ONE;
    end
  end

  assign tick = run && (pre == PRE_MAX);

endmodule

// File: rtl/pwm_servo_multi.sv
// N-channel servo PWM with shared us timebase and double-buffered duties; PWM_CLAMP_EN clamps writes.
// Latency: pwm_out is registered, one clk after the count/duty it reflects.
// Backpressure: none; writes always accepted, out-of-range channel writes are dropped.
module pwm_servo_multi
  import pwm_pkg::*;
#(
  parameter int  N_CH     = 4,
  parameter int  CLK_DIV  = 100,
  parameter int  CNT_W    = CNT_W_DEF,
  parameter int  DUTY_RST = DUTY_RST_DEF,
  parameter int  MIN_US   = MIN_US_DEF,
  parameter int  MAX_US   = MAX_US_DEF,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] period,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [CNT_W-1:0] wr_duty,
  output logic [N_CH-1:0]  pwm_out,
  output logic             frame_start,
  output logic             running
);

`ifdef PWM_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] DUTY_INIT = CNT_W'(DUTY_RST);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] LO_US     = CNT_W'(MIN_US);
  localparam logic [CNT_W-1:0] HI_US     = CNT_W'(MAX_US);

  // Zero always means "channel off" and bypasses the clamp.
  function automatic logic [CNT_W-1:0] duty_store(input logic [CNT_W-1:0] d);
    if (!CLAMP_EN || d == '0) return d;
    if (d < LO_US) return LO_US;
    if (d > HI_US) return HI_US;
    return d;
  endfunction

  pwm_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] period_act;
  logic [CNT_W-1:0] shadow   [N_CH];
  logic [CNT_W-1:0] duty_act [N_CH];
  logic             tick;
  logic             wr_hit;
  logic             frame_end;

  pwm_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .run     (state == RUN),
    .tick    (tick)
  );

  assign wr_hit = wr_en && (int'(wr_ch) < N_CH);

  // A zero period never matches a count, so it reloads on every tick instead.
  assign frame_end = (period_act == '0) || (cnt == period_act - CNT_ONE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < N_CH; i++) shadow[i] <= DUTY_INIT;
    end else if (wr_hit) begin
      shadow[wr_ch] <= duty_store(wr_duty);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      period_act  <= '0;
      pwm_out     <= '0;
      frame_start <= 1'b0;
      running     <= 1'b0;
      for (int i = 0; i < N_CH; i++) duty_act[i] <= DUTY_INIT;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          cnt     <= '0;
          pwm_out <= '0;
          running <= 1'b0;
          if (enable) begin
            state       <= RUN;
            running     <= 1'b1;
            frame_start <= 1'b1;
            period_act  <= period;
            for (int i = 0; i < N_CH; i++) duty_act[i] <= shadow[i];
          end
        end
        RUN: begin
          if (!enable) begin
            state   <= IDLE;
            running <= 1'b0;
            cnt     <= '0;
            pwm_out <= '0;
          end else begin
            for (int i = 0; i < N_CH; i++)
              pwm_out[i] <= (period_act != '0) && (cnt < duty_act[i]);
            if (tick) begin
              if (frame_end) begin
                cnt         <= '0;
                period_act  <= period;
                // Idle reloads while the period stays zero are not real frames.
                frame_start <= (period_act != '0) || (period != '0);
                for (int i = 0; i < N_CH; i++) duty_act[i] <= shadow[i];
              end else begin
                cnt <= cnt + CNT_ONE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_servo_multi.sv
// Directed bench for pwm_servo_multi with CLK_DIV=4, N_CH=4: frames, double-buffering,
// duty/period boundaries, enable drop and async reset.
module tb_pwm_servo_multi;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [15:0] period;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [15:0] wr_duty;
  logic [3:0]  pwm_out;
  logic        frame_start;
  logic        running;

  int checks   = 0;
  int failures = 0;
  int hi[4];
  int fs_cnt;

  always #5 clk = ~clk;

  pwm_servo_multi #(
    .N_CH    (4),
    .CLK_DIV (4),
    .CNT_W   (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .period      (period),
    .wr_en       (wr_en),
    .wr_ch       (wr_ch),
    .wr_duty     (wr_duty),
    .pwm_out     (pwm_out),
    .frame_start (frame_start),
    .running     (running)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Count high cycles per channel and frame_start pulses over n clks.
  task automatic measure(input int n);
    fs_cnt = 0;
    for (int c = 0; c < 4; c++) hi[c] = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) if (pwm_out[c]) hi[c]++;
      if (frame_start) fs_cnt++;
    end
  endtask

  task automatic wr(input logic [1:0] ch, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_duty = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_fs(input int limit);
    int k = 0;
    while (k < limit && !frame_start) begin
      @(negedge clk);
      k++;
    end
    chk("fs_sync", {31'b0, frame_start}, 32'd1);
  endtask

  task automatic chk_hi(input string tag, input int e0, input int e1, input int e2, input int e3,
                        input int efs);
    chk({tag, "_ch0"}, hi[0], e0);
    chk({tag, "_ch1"}, hi[1], e1);
    chk({tag, "_ch2"}, hi[2], e2);
    chk({tag, "_ch3"}, hi[3], e3);
    chk({tag, "_fs"},  fs_cnt, efs);
  endtask

  initial begin
    reset_n = 1'b0;
    enable  = 1'b0;
    period  = 16'd20;
    wr_en   = 1'b0;
    wr_ch   = 2'd0;
    wr_duty = 16'd0;
    repeat (3) @(negedge clk);
    chk("rst_pwm", {28'b0, pwm_out}, 32'd0);
    chk("rst_fs", {31'b0, frame_start}, 32'd0);
    chk("rst_run", {31'b0, running}, 32'd0);

    reset_n = 1'b1;
    @(negedge clk);
    for (int c = 0; c < 4; c++) wr(c[1:0], 16'd5);
    chk("idle_pwm", {28'b0, pwm_out}, 32'd0);

    // Frame load edge E0: frame_start and running rise, outputs still low.
    enable = 1'b1;
    @(negedge clk);
    chk("e0_fs", {31'b0, frame_start}, 32'd1);
    chk("e0_run", {31'b0, running}, 32'd1);
    chk("e0_pwm", {28'b0, pwm_out}, 32'd0);
    measure(80);
    chk_hi("f1", 20, 20, 20, 20, 1);
    chk("f1_end_fs", {31'b0, frame_start}, 32'd1);

    // Mid-frame write to ch1 must not affect the frame in progress.
    repeat (10) @(negedge clk);
    wr(2'd1, 16'd12);
    measure(69);
    chk_hi("f2_tail", 9, 9, 9, 9, 1);
    measure(80);
    chk_hi("f3", 20, 48, 20, 20, 1);

    // Write ch2 on the very clk that loads the next frame.
    measure(79);
    wr(2'd2, 16'd8);
    chk("wr_on_load_fs", {31'b0, frame_start}, 32'd1);
    measure(80);
    chk_hi("f5_old", 20, 48, 20, 20, 1);
    measure(80);
    chk_hi("f6_new", 20, 48, 32, 20, 1);

    // Duty 0 and duty above period.
    wr(2'd0, 16'd0);
    wr(2'd3, 16'd25);
    measure(78);
    measure(80);
    chk_hi("f8_bound", 0, 48, 32, 80, 1);

    // Zero period: outputs low, no further frame_start.
    period = 16'd0;
    measure(80);
    chk("p0_load_fs", fs_cnt, 32'd1);
    measure(100);
    chk_hi("p0", 0, 0, 0, 0, 0);
    chk("p0_run", {31'b0, running}, 32'd1);

    period = 16'd20;
    wait_fs(40);

    // Drop enable mid-pulse, re-enable 10 clks later.
    repeat (9) @(negedge clk);
    chk("pre_drop_pwm", {28'b0, pwm_out}, 32'hE);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_pwm", {28'b0, pwm_out}, 32'd0);
    chk("drop_run", {31'b0, running}, 32'd0);
    repeat (9) @(negedge clk);
    chk("off_pwm", {28'b0, pwm_out}, 32'd0);
    enable = 1'b1;
    @(negedge clk);
    chk("reen_fs", {31'b0, frame_start}, 32'd1);
    chk("reen_run", {31'b0, running}, 32'd1);
    measure(80);
    chk_hi("reen", 0, 48, 32, 80, 1);

    // Async reset mid-frame clears outputs at once and restores centre duties.
    repeat (5) @(negedge clk);
    chk("pre_rst_pwm", {28'b0, pwm_out}, 32'hE);
    reset_n = 1'b0;
    #1;
    chk("arst_pwm", {28'b0, pwm_out}, 32'd0);
    chk("arst_run", {31'b0, running}, 32'd0);
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    chk("post_rst_fs", {31'b0, frame_start}, 32'd1);
    measure(80);
    chk_hi("post_rst", 80, 80, 80, 80, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
